// File: rtl/es1_spu_pkg.sv
// Shared constants for the ES1 SPU operator library: device names and mode strings.
package es1_spu_pkg;

    localparam string DEVICE_RTL             = "RTL";
    localparam string DEVICE_ULTRASCALE_PLUS = "ULTRASCALE_PLUS";

    localparam string SIM_TRUE    = "true";
    localparam string SIM_FALSE   = "false";
    localparam string DEBUG_TRUE  = "true";
    localparam string DEBUG_FALSE = "false";

endpackage

// File: rtl/es1_spu_delay.sv
// Clock-enable-gated delay line of LATENCY stages (0 = passthrough), synchronous reset.
module es1_spu_delay
    import es1_spu_pkg::*;
#(
    parameter int unsigned LATENCY    = 1,
    parameter type         data_t     = logic [7:0],
    parameter data_t       RESET_DATA = '0
) (
    input  logic  i_clk,
    input  logic  i_reset,
    input  logic  i_cke,
    input  data_t i_data,
    output data_t o_data
);

    if (LATENCY == 0) begin : g_pass
        assign o_data = i_data;
    end else begin : g_delay
        data_t r_stage [LATENCY];

        always_ff @(posedge i_clk) begin
            if (i_reset) begin
                for (int i = 0; i < int'(LATENCY); i++) begin
                    r_stage[i] <= RESET_DATA;
                end
            end else if (i_cke) begin
                r_stage[0] <= i_data;
                for (int i = 1; i < int'(LATENCY); i++) begin
                    r_stage[i] <= r_stage[i-1];
                end
            end
        end

        assign o_data = r_stage[LATENCY-1];
    end

endmodule

// File: rtl/es1_spu_op_reg.sv
// Sample-and-hold register with cke-gated output pipeline of LATENCY total stages.
// Optional embedded checks: define ES1_SPU_OP_REG_ASSERT_EN (active when SIMULATION=="true").
module es1_spu_op_reg
    import es1_spu_pkg::*;
#(
    parameter int unsigned LATENCY    = 1,
    parameter int unsigned DATA_BITS  = 8,
    parameter type         data_t     = logic [DATA_BITS-1:0],
    parameter data_t       CLEAR_DATA = '0,
    parameter string       DEVICE     = DEVICE_RTL,
    parameter string       SIMULATION = SIM_FALSE,
    parameter string       DEBUG      = DEBUG_FALSE
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  cke,
    input  data_t s_data,
    input  logic  s_clear,
    input  logic  s_valid,
    output data_t m_data
);

    if (LATENCY < 1 || DEVICE == ""
        || (SIMULATION != SIM_TRUE && SIMULATION != SIM_FALSE)
        || (DEBUG != DEBUG_TRUE && DEBUG != DEBUG_FALSE)) begin : g_bad_param
        $error("es1_spu_op_reg: illegal parameter setting");
    end

    data_t r_hold;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold <= CLEAR_DATA;
        end else if (cke) begin
            if (s_clear) begin
                r_hold <= CLEAR_DATA;
            end else if (s_valid) begin
                r_hold <= s_data;
            end
        end
    end

    // The hold register is the first latency stage; the delay line adds the rest.
    if (LATENCY <= 1) begin : g_direct
        assign m_data = r_hold;
    end else begin : g_pipe
        es1_spu_delay #(
            .LATENCY    (LATENCY - 1),
            .data_t     (data_t),
            .RESET_DATA (CLEAR_DATA)
        ) u_delay (
            .i_clk   (clk),
            .i_reset (reset),
            .i_cke   (cke),
            .i_data  (r_hold),
            .o_data  (m_data)
        );
    end

`ifdef ES1_SPU_OP_REG_ASSERT_EN
    if (SIMULATION == SIM_TRUE) begin : g_assert
        logic  r_prev_cke;
        logic  r_prev_run;
        data_t r_prev_m;

        always_ff @(posedge clk) begin
            r_prev_cke <= cke;
            r_prev_run <= !reset;
            r_prev_m   <= m_data;
        end

        always @(posedge clk) begin
            if (reset === 1'b0) begin
                assert (!$isunknown({cke, s_clear, s_valid}))
                    else $error("%m: X/Z on cke/s_clear/s_valid");
                assert (!(s_valid === 1'b1 && $isunknown(s_data)))
                    else $error("%m: X/Z on s_data while s_valid");
            end
            // m_data as seen here was produced by the previous edge.
            if (r_prev_run === 1'b1 && r_prev_cke === 1'b0) begin
                assert (m_data === r_prev_m)
                    else $error("%m: m_data changed across a cke=0 edge");
            end
        end
    end
`endif

endmodule

// File: tb/tb_es1_spu_op_reg.sv
// Bench for es1_spu_op_reg: directed vector table plus randomized run against queue models.
module tb_es1_spu_op_reg;

    typedef logic signed [7:0] sbyte_t;

    localparam logic [15:0] CA = 16'd123;
    localparam logic [15:0] CB = 16'd1;
    localparam logic [15:0] CC = 16'hA5C3;

    logic        clk = 1'b0;
    logic        rst;
    logic        cke;
    logic        clr;
    logic        vld;
    logic [15:0] din;

    logic [7:0]  m_a;
    logic [0:0]  m_b;
    logic [15:0] m_c;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    es1_spu_op_reg #(
        .LATENCY    (3),
        .DATA_BITS  (8),
        .data_t     (sbyte_t),
        .CLEAR_DATA (8'sd123),
        .SIMULATION ("true")
    ) dut_a (
        .clk     (clk),
        .reset   (rst),
        .cke     (cke),
        .s_data  (din[7:0]),
        .s_clear (clr),
        .s_valid (vld),
        .m_data  (m_a)
    );

    es1_spu_op_reg #(
        .LATENCY    (1),
        .DATA_BITS  (1),
        .CLEAR_DATA (1'b1),
        .SIMULATION ("true")
    ) dut_b (
        .clk     (clk),
        .reset   (rst),
        .cke     (cke),
        .s_data  (din[0:0]),
        .s_clear (clr),
        .s_valid (vld),
        .m_data  (m_b)
    );

    es1_spu_op_reg #(
        .LATENCY    (2),
        .DATA_BITS  (16),
        .CLEAR_DATA (16'hA5C3),
        .DEVICE     ("ULTRASCALE_PLUS"),
        .SIMULATION ("true")
    ) dut_c (
        .clk     (clk),
        .reset   (rst),
        .cke     (cke),
        .s_data  (din),
        .s_clear (clr),
        .s_valid (vld),
        .m_data  (m_c)
    );

    // Each model queue holds the value every pipeline position will show, oldest first;
    // its length is the configured latency and its front is the expected m_data.
    logic [15:0] qa[$];
    logic [15:0] qb[$];
    logic [15:0] qc[$];

    function automatic logic [15:0] next_hold(logic [15:0] held, logic [15:0] cval,
                                              logic [15:0] mask);
        if (clr)      return cval;
        else if (vld) return din & mask;
        else          return held;
    endfunction

    task automatic model_step();
        if (rst) begin
            qa = '{CA, CA, CA};
            qb = '{CB};
            qc = '{CC, CC};
        end else if (cke) begin
            qa.push_back(next_hold(qa[$], CA, 16'h00FF));
            void'(qa.pop_front());
            qb.push_back(next_hold(qb[$], CB, 16'h0001));
            void'(qb.pop_front());
            qc.push_back(next_hold(qc[$], CC, 16'hFFFF));
            void'(qc.pop_front());
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check(string name, logic [15:0] act, logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic       rst;
        logic       cke;
        logic       clr;
        logic       vld;
        logic [7:0] data;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(logic r, logic ce, logic c, logic v, logic [7:0] d, logic [7:0] e);
        vecs.push_back('{rst: r, cke: ce, clr: c, vld: v, data: d, exp: e});
    endtask

    initial begin
        rst = 1'b1;
        cke = 1'b1;
        clr = 1'b0;
        vld = 1'b0;
        din = '0;
        qa = '{CA, CA, CA};
        qb = '{CB};
        qc = '{CC, CC};

        // reset (also with cke low) and idle
        add(1, 1, 0, 0, 8'd0,   8'd123);
        add(1, 0, 0, 1, 8'd55,  8'd123);
        add(0, 1, 0, 0, 8'd0,   8'd123);
        add(0, 1, 0, 0, 8'd0,   8'd123);
        // hold/update sequence
        add(0, 1, 0, 1, 8'd2,   8'd123);
        add(0, 1, 0, 0, 8'd5,   8'd123);
        add(0, 1, 0, 1, 8'd1,   8'd2);
        add(0, 1, 0, 0, 8'd0,   8'd2);
        add(0, 1, 0, 0, 8'd99,  8'd1);
        add(0, 1, 0, 1, 8'd2,   8'd1);
        add(0, 1, 0, 0, 8'hFE,  8'd1);
        add(0, 1, 0, 0, 8'd0,   8'd2);
        add(0, 1, 0, 0, 8'd0,   8'd2);
        // stall with a pending value: 4 is ignored, 7 arrives one cycle later
        add(0, 1, 0, 1, 8'd7,   8'd2);
        add(0, 0, 0, 1, 8'd4,   8'd2);
        add(0, 1, 0, 0, 8'd0,   8'd2);
        add(0, 1, 0, 0, 8'd0,   8'd7);
        add(0, 1, 0, 0, 8'd0,   8'd7);
        // clear wins over valid
        add(0, 1, 1, 1, 8'd99,  8'd7);
        add(0, 1, 0, 0, 8'hF7,  8'd7);
        add(0, 1, 0, 0, 8'd0,   8'd123);
        add(0, 1, 0, 0, 8'd0,   8'd123);
        add(0, 1, 0, 0, 8'd0,   8'd123);
        // negative value round trip
        add(0, 1, 0, 1, 8'h80,  8'd123);
        add(0, 1, 0, 0, 8'd0,   8'd123);
        add(0, 1, 0, 0, 8'd0,   8'h80);
        // reset mid-stream discards in-flight data
        add(0, 1, 0, 1, 8'd50,  8'h80);
        add(0, 1, 0, 1, 8'd60,  8'h80);
        add(1, 1, 0, 0, 8'd0,   8'd123);
        add(0, 1, 0, 0, 8'd0,   8'd123);
        add(0, 1, 0, 0, 8'd0,   8'd123);
        add(0, 1, 0, 0, 8'd0,   8'd123);
        add(0, 1, 0, 1, 8'd11,  8'd123);
        add(0, 1, 0, 0, 8'd0,   8'd123);
        add(0, 1, 0, 0, 8'd0,   8'd11);

        foreach (vecs[i]) begin
            rst = vecs[i].rst;
            cke = vecs[i].cke;
            clr = vecs[i].clr;
            vld = vecs[i].vld;
            din = {8'h00, vecs[i].data};
            cycle();
            check($sformatf("vec%0d", i), {8'h00, m_a}, {8'h00, vecs[i].exp});
        end

        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 63) == 0);
            cke = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 7) == 0);
            vld = 1'($urandom_range(0, 1));
            din = 16'($urandom);
            cycle();
            check("rand_a", {8'h00, m_a}, qa[0]);
            check("rand_b", {15'h0, m_b}, qb[0]);
            check("rand_c", m_c, qc[0]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
